// File: rtl/dmem_responder.sv
// Data-memory responder: byte-strobed word RAM behind independent write and read channels,
// each with a programmable wait-state count and out-of-window read error response.
module dmem_responder #(
    parameter int unsigned SIZE = 65536,
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter int unsigned WLAT = 0,
    parameter int unsigned RLAT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wready,
    output logic        wvalid,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        rready,
    output logic        rvalid,
    input  logic [31:0] raddr,
    output logic        rresp,
    output logic [31:0] rdata
);

    localparam int unsigned WORDS  = SIZE / 4;
    localparam int unsigned IW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0]  WLAT4  = 4'(WLAT);
    localparam logic [3:0]  RLAT4  = 4'(RLAT);
    localparam logic [32:0] SIZE33 = 33'(SIZE);

    logic [31:0]   mem [WORDS];
    logic [3:0]    wcnt_q;
    logic [3:0]    rcnt_q;
    logic [31:0]   woff;
    logic [31:0]   roff;
    logic          win;
    logic          rin;
    logic [IW-1:0] widx;
    logic [IW-1:0] ridx;

    // Offset compare is equivalent to BASE <= addr < BASE+SIZE and cannot overflow at the top.
    assign woff = waddr - BASE;
    assign roff = raddr - BASE;
    assign win  = {1'b0, woff} < SIZE33;
    assign rin  = {1'b0, roff} < SIZE33;
    assign widx = woff[IW+1:2];
    assign ridx = roff[IW+1:2];

    assign wvalid = wready && (wcnt_q == 4'd0);
    assign rvalid = rready && (rcnt_q == 4'd0);

    // Dropping the request reloads the counter so a retried access waits the full count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q <= WLAT4;
        end else if (!wready || wvalid) begin
            wcnt_q <= WLAT4;
        end else begin
            wcnt_q <= wcnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt_q <= RLAT4;
        end else if (!rready || rvalid) begin
            rcnt_q <= RLAT4;
        end else begin
            rcnt_q <= rcnt_q - 4'd1;
        end
    end

    // Read samples the pre-write word, so a same-cycle write to the same word is seen next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rresp <= 1'b0;
            rdata <= 32'd0;
        end else if (rvalid) begin
            rresp <= rin;
            rdata <= rin ? mem[ridx] : 32'd0;
        end
    end

    // RAM has no reset; contents persist across reset.
    always_ff @(posedge clk) begin
        if (wvalid && win) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench: a zero-wait and a wait-state instance of dmem_responder
// compared against a word-map model with latency expectations taken from the parameters.
module tb_dmem_responder;

    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h8000_0000;
    localparam int unsigned SIZE0 = 65536;
    localparam int unsigned SIZE1 = 4096;
    localparam int unsigned WLAT0 = 0;
    localparam int unsigned RLAT0 = 0;
    localparam int unsigned WLAT1 = 2;
    localparam int unsigned RLAT1 = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        wreq   [2];
    logic        wvalid [2];
    logic [31:0] waddr  [2];
    logic [31:0] wdata  [2];
    logic [3:0]  wstrb  [2];
    logic        rreq   [2];
    logic        rvalid [2];
    logic [31:0] raddr  [2];
    logic        rresp  [2];
    logic [31:0] rdata  [2];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model [longint unsigned];
    logic [31:0] last_rd [2];
    logic [31:0] pool [2][8];

    always #5 clk = ~clk;

    dmem_responder #(.SIZE(SIZE0), .BASE(BASE0), .WLAT(WLAT0), .RLAT(RLAT0)) u_fast (
        .clk(clk), .reset(reset),
        .wready(wreq[0]), .wvalid(wvalid[0]), .waddr(waddr[0]), .wdata(wdata[0]),
        .wstrb(wstrb[0]),
        .rready(rreq[0]), .rvalid(rvalid[0]), .raddr(raddr[0]), .rresp(rresp[0]),
        .rdata(rdata[0])
    );

    dmem_responder #(.SIZE(SIZE1), .BASE(BASE1), .WLAT(WLAT1), .RLAT(RLAT1)) u_slow (
        .clk(clk), .reset(reset),
        .wready(wreq[1]), .wvalid(wvalid[1]), .waddr(waddr[1]), .wdata(wdata[1]),
        .wstrb(wstrb[1]),
        .rready(rreq[1]), .rvalid(rvalid[1]), .raddr(raddr[1]), .rresp(rresp[1]),
        .rdata(rdata[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input int d, input logic [31:0] a);
        longint unsigned la = a;
        longint unsigned lb = (d == 1) ? BASE1 : BASE0;
        longint unsigned ls = (d == 1) ? SIZE1 : SIZE0;
        return (la >= lb) && (la < lb + ls);
    endfunction

    function automatic longint unsigned key(input int d, input logic [31:0] a);
        logic [31:0] off = a - ((d == 1) ? BASE1 : BASE0);
        return (longint'(d) << 40) | longint'(off >> 2);
    endfunction

    function automatic logic [31:0] model_rd(input int d, input logic [31:0] a);
        if (!in_win(d, a)) return 32'd0;
        if (model.exists(key(d, a))) return model[key(d, a)];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] oow_addr(input int d);
        if (d == 0) return $urandom | 32'h0001_0000;
        if ($urandom_range(0, 1) == 0) return $urandom & 32'h7FFF_FFFF;
        return 32'h8000_1000 + ($urandom & 32'h0FFF_FFFC);
    endfunction

    // Enters and leaves at posedge+1; model updated at the handshake edge.
    task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] data,
                            input logic [3:0] strb);
        int          cyc = 0;
        bit          ok  = 0;
        logic [31:0] w;
        wreq[d] = 1'b1; waddr[d] = a; wdata[d] = data; wstrb[d] = strb;
        while (!ok && cyc <= 40) begin
            @(negedge clk);
            if (wvalid[d]) ok = 1;
            else begin cyc++; @(posedge clk); #1; end
        end
        check($sformatf("wlat%0d", d), 32'(cyc), (d == 1) ? WLAT1 : WLAT0);
        if (ok) begin
            @(posedge clk);
            if (in_win(d, a)) begin
                w = model.exists(key(d, a)) ? model[key(d, a)] : 32'hxxxx_xxxx;
                for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = data[8*i +: 8];
                model[key(d, a)] = w;
            end
            #1;
        end
        wreq[d] = 1'b0;
        waddr[d] = $urandom;
    endtask

    task automatic do_read(input int d, input logic [31:0] a, output logic [31:0] got);
        int          cyc = 0;
        bit          ok  = 0;
        logic [31:0] exp_d = 32'd0;
        logic        exp_r = 1'b0;
        rreq[d] = 1'b1; raddr[d] = a;
        while (!ok && cyc <= 40) begin
            @(negedge clk);
            if (rvalid[d]) begin
                ok = 1; exp_r = in_win(d, a); exp_d = model_rd(d, a);
            end else begin
                cyc++; @(posedge clk); #1;
            end
        end
        check($sformatf("rlat%0d", d), 32'(cyc), (d == 1) ? RLAT1 : RLAT0);
        got = rdata[d];
        if (ok) begin
            @(posedge clk); #1;
            rreq[d] = 1'b0;
            raddr[d] = $urandom;
            got = rdata[d];
            check($sformatf("rresp%0d", d), 32'(rresp[d]), 32'(exp_r));
            check($sformatf("rdata%0d", d), rdata[d], exp_d);
            last_rd[d] = exp_d;
        end
        rreq[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rand_loop(input int d);
        logic [31:0] a;
        logic [31:0] got;
        int          op;
        for (int i = 0; i < 8; i++) begin
            pool[d][i] = ((d == 1) ? BASE1 : BASE0) +
                         ($urandom_range(0, ((d == 1) ? SIZE1 : SIZE0) / 4 - 1) << 2);
            do_write(d, pool[d][i], $urandom, 4'hF);
        end
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 9);
            a  = pool[d][$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            if (op <= 3)      do_write(d, a, $urandom, 4'($urandom_range(0, 15)));
            else if (op <= 7) do_read(d, a, got);
            else if (op == 8) do_read(d, oow_addr(d), got);
            else              do_write(d, oow_addr(d), $urandom, 4'hF);
            idle($urandom_range(0, 2));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        for (int d = 0; d < 2; d++) begin
            wreq[d] = 1'b0; rreq[d] = 1'b0; waddr[d] = '0; wdata[d] = '0;
            wstrb[d] = '0; raddr[d] = '0; last_rd[d] = '0;
        end
        reset = 1'b1;
        wreq[0] = 1'b1; wreq[1] = 1'b1;
        #12;
        check("rst_wvalid_fast", 32'(wvalid[0]), 32'd1);
        check("rst_wvalid_slow", 32'(wvalid[1]), 32'd0);
        check("rst_rvalid_fast", 32'(rvalid[0]), 32'd0);
        check("rst_rresp_slow", 32'(rresp[1]), 32'd0);
        check("rst_rdata_fast", rdata[0], 32'd0);
        check("rst_rdata_slow", rdata[1], 32'd0);
        wreq[0] = 1'b0; wreq[1] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);

        // Basic write/read with zero wait states, then byte strobes with offset address.
        do_write(0, 32'h100, 32'h1234_5678, 4'hF);
        do_read(0, 32'h100, got);
        check("tp1_data", got, 32'h1234_5678);
        do_write(0, 32'h100, 32'hAABB_CCDD, 4'b0101);
        do_read(0, 32'h102, got);
        check("tp2_strobe", got, 32'h12BB_56DD);
        do_write(0, 32'h104, 32'h5555_5555, 4'h0);
        do_write(0, 32'h104, 32'h0BAD_F00D, 4'hF);
        do_write(0, 32'h104, 32'hFFFF_FFFF, 4'h0);
        do_read(0, 32'h104, got);

        // Wait states: back-to-back reads, and an abandoned read restarting the wait.
        do_write(1, BASE1 + 32'h10, 32'hDEAD_BEEF, 4'hF);
        do_write(1, BASE1 + 32'h14, 32'h0123_4567, 4'hF);
        do_read(1, BASE1 + 32'h10, got);
        do_read(1, BASE1 + 32'h14, got);
        rreq[1] = 1'b1; raddr[1] = BASE1 + 32'h10;
        repeat (2) begin
            @(negedge clk);
            check("tp4_no_rvalid", 32'(rvalid[1]), 32'd0);
            @(posedge clk); #1;
        end
        rreq[1] = 1'b0;
        idle(1);
        do_read(1, BASE1 + 32'h10, got);
        wreq[1] = 1'b1; waddr[1] = BASE1 + 32'h18; wdata[1] = 32'h1; wstrb[1] = 4'hF;
        idle(1);
        wreq[1] = 1'b0;
        idle(1);
        do_write(1, BASE1 + 32'h18, 32'h7777_0000, 4'hC);
        do_write(1, BASE1 + 32'h18, 32'h0000_8888, 4'h3);
        do_read(1, BASE1 + 32'h18, got);
        check("slow_strobes", got, 32'h7777_8888);

        // Window edges: just past the top, just below the base, and a dropped write.
        do_read(0, BASE0 + SIZE0, got);
        do_write(0, 32'h0, 32'hCAFE_F00D, 4'hF);
        do_write(0, BASE0 + SIZE0, 32'hFFFF_FFFF, 4'hF);
        do_read(0, 32'h0, got);
        check("tp5_base_kept", got, 32'hCAFE_F00D);
        do_read(0, 32'hFFFC, got);
        do_read(1, BASE1 - 32'd4, got);
        do_read(1, BASE1 + SIZE1, got);
        do_write(1, BASE1 + SIZE1 - 32'd4, 32'hA5A5_5A5A, 4'hF);
        do_read(1, BASE1 + SIZE1 - 32'd1, got);

        // Same-cycle read and write to one word.
        do_write(0, 32'h200, 32'h1, 4'hF);
        fork
            do_write(0, 32'h200, 32'h2, 4'hF);
            do_read(0, 32'h200, got);
        join
        check("tp6_old_data", got, 32'h1);
        do_read(0, 32'h200, got);
        check("tp6_new_data", got, 32'h2);

        // Read data holds while idle and while addresses wander.
        idle(3);
        check("hold_fast", rdata[0], last_rd[0]);

        // Reset in the middle of a read wait.
        do_read(1, BASE1 + 32'h10, got);
        rreq[1] = 1'b1; raddr[1] = BASE1 + 32'h14;
        idle(2);
        reset = 1'b1;
        #1;
        check("midrst_rresp", 32'(rresp[1]), 32'd0);
        check("midrst_rdata", rdata[1], 32'd0);
        check("midrst_rvalid", 32'(rvalid[1]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        do_read(1, BASE1 + 32'h14, got);
        check("midrst_mem_kept", got, 32'h0123_4567);

        fork
            rand_loop(0);
            rand_loop(1);
        join

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the core's split data-memory write/read interface.
- Stores words in an internal RAM. Applies byte strobes on writes and returns read data one cycle after the address is accepted.
- Inserts a programmable number of wait states per channel.
- Flags reads outside its window with an error response.
- Sits behind the top-level data bus. Used as the simulation/FPGA data RAM and as a bench model for the core's load/store path.

Parameters:
- SIZE, 65536: RAM size in bytes; power of two, minimum 4.
- BASE, 32'h0000_0000: byte address of the first RAM location; aligned to SIZE.
- WLAT, 0: write wait states, 0..15.
- RLAT, 0: read wait states, 0..15.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wready  input  1  initiator has a write request (waddr/wdata/wstrb valid).
- wvalid  output  1  responder accepts the write this cycle.
- waddr  input  32  write byte address.
- wdata  input  32  write data.
- wstrb  input  4  byte enables; bit i selects wdata[8i+7:8i].
- rready  input  1  initiator has a read request (raddr valid).
- rvalid  output  1  responder accepts the read address this cycle.
- raddr  input  32  read byte address.
- rresp  output  1  1 = read OK, 0 = address out of window; valid the cycle after acceptance.
- rdata  output  32  read data; valid the cycle after acceptance.

Behaviour:
- Handshakes:
  - A write completes in a cycle where wready && wvalid.
  - A read address is accepted in a cycle where rready && rvalid.
  - The read and write channels are fully independent and may complete in the same cycle.
- Wait states, write channel (read identical with rcnt/RLAT):
  - 4-bit counter wcnt; wvalid = wready && (wcnt == 0), combinational.
  - wready=1, wcnt!=0: wcnt decrements.
  - Handshake: wcnt reloads WLAT.
  - wready=0: wcnt reloads WLAT, so an abandoned request restarts the full wait.
  - WLAT=0: wvalid follows wready the same cycle.
- Address decode:
  - In window when BASE <= addr < BASE+SIZE.
  - Word index = (addr - BASE) >> 2; addr[1:0] is ignored.
- Write commit, at the handshake edge:
  - Each byte lane with wstrb[i]=1 is updated.
  - wstrb=0 is a legal no-op.
  - An out-of-window write is accepted and dropped silently.
- Read data:
  - On the handshake edge, rdata is registered with the full word and rresp=1.
  - Out-of-window: rdata=0, rresp=0.
  - rdata/rresp hold their value until the next read handshake.
- Same-cycle read and write to the same word: the read returns the old (pre-write) data. The write is visible to the next read.
- Reset, asserted any time including mid-wait:
  - wcnt=WLAT, rcnt=RLAT, rdata=0, rresp=0.
  - wvalid/rvalid follow from the counters, so they are 0 unless WLAT=0/RLAT=0 and the initiator is requesting.
  - RAM contents are not cleared and are X until written.
- Outputs never depend on raddr/waddr combinationally; only rvalid/wvalid depend on the ready inputs.

Test Plan:
1. WLAT=RLAT=0: write 0x12345678 to 0x100 with wstrb=4'hF, then read 0x100.
   -> wvalid=1 in the same cycle as wready; next cycle after the read handshake rdata=0x12345678, rresp=1.
2. Byte strobes: word 0x100=0x12345678, write wdata=0xAABBCCDD with wstrb=4'b0101, read 0x102.
   -> rdata=0x12BB56DD; addr[1:0] ignored.
3. RLAT=3, rready held high.
   -> rvalid low 3 cycles, high on the 4th; rdata valid on the 5th; a back-to-back second read again waits 3 cycles.
4. RLAT=3: drop rready after 2 cycles, re-assert.
   -> full 3-cycle wait again before rvalid.
5. Out of window: read BASE+SIZE.
   -> rresp=0, rdata=0.
   Write 0xFFFFFFFF to BASE+SIZE, then read BASE.
   -> BASE contents unchanged.
6. Simultaneous read and write to 0x200 (old 0x1, new 0x2).
   -> read returns 0x1; the following read returns 0x2.
   Assert reset during an RLAT=3 wait.
   -> rresp=0, rdata=0, and a full 3-cycle wait after release.
